alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_if.sv | 25 ++
 rtl/alu.sv | 130 +++++++++++++
 tb/tb_alu.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Operand/result bundle between an ALU client (master) and the ALU (slave).
interface alu_if #(
    parameter int WIDTH = 8
);
    logic             alu_sel;
    logic [2:0]       alu_order;
    logic [WIDTH-1:0] reg_1;
    logic [WIDTH-1:0] reg_2;
    logic [WIDTH-1:0] alu_out;
    logic             alu_valid;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             flag_n;

    modport master (
        output alu_sel, alu_order, reg_1, reg_2,
        input  alu_out, alu_valid, flag_z, flag_c, flag_v, flag_n
    );

    modport slave (
        input  alu_sel, alu_order, reg_1, reg_2,
        output alu_out, alu_valid, flag_z, flag_c, flag_v, flag_n
    );
endinterface

// File: rtl/alu.sv
// Single-cycle registered ALU: ADD/SUB/AND/OR/XOR/NOT/SHL/SHR with Z/C/V/N flags.
// Define ALU_FLAGS_EN to compute the flags; otherwise the flag ports are tied to 0.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic    clk,
    input  logic    rst,
    alu_if.slave    bus
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    logic signed [WIDTH-1:0] a_p0;
    logic signed [WIDTH-1:0] b_p0;
    logic signed [WIDTH-1:0] res_p0;

    logic        [WIDTH-1:0] out_p1;
    logic                    vld_p1;

    assign a_p0 = bus.reg_1;
    assign b_p0 = bus.reg_2;

    // Stage p0: combinational result from the operands presented this cycle
    always_comb begin
        res_p0 = '0;
        case (op_e'(bus.alu_order))
            OP_ADD:  res_p0 = a_p0 + b_p0;
            OP_SUB:  res_p0 = a_p0 - b_p0;
            OP_AND:  res_p0 = a_p0 & b_p0;
            OP_OR:   res_p0 = a_p0 | b_p0;
            OP_XOR:  res_p0 = a_p0 ^ b_p0;
            OP_NOT:  res_p0 = ~a_p0;
            OP_SHL:  res_p0 = {a_p0[WIDTH-2:0], 1'b0};
            OP_SHR:  res_p0 = {1'b0, a_p0[WIDTH-1:1]};
            default: res_p0 = '0;
        endcase
    end

    // Stage p1: result register; holds while no operation is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            out_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= bus.alu_sel;
            if (bus.alu_sel) begin
                out_p1 <= res_p0;
            end
        end
    end

    assign bus.alu_out   = out_p1;
    assign bus.alu_valid = vld_p1;

`ifdef ALU_FLAGS_EN

    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] r);
        return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // For subtraction the operand signs must differ for the result to overflow.
    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] r);
        return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    logic [WIDTH:0] sum_ext_p0;
    logic [WIDTH:0] diff_ext_p0;
    logic           carry_p0;
    logic           ovf_p0;
    logic [3:0]     flags_p1;

    assign sum_ext_p0  = {1'b0, bus.reg_1} + {1'b0, bus.reg_2};
    assign diff_ext_p0 = {1'b0, bus.reg_1} - {1'b0, bus.reg_2};

    // Stage p0: carry is the true carry for ADD and the borrow for SUB
    always_comb begin
        carry_p0 = 1'b0;
        ovf_p0   = 1'b0;
        case (op_e'(bus.alu_order))
            OP_ADD: begin
                carry_p0 = sum_ext_p0[WIDTH];
                ovf_p0   = add_ovf(a_p0, b_p0, res_p0);
            end
            OP_SUB: begin
                carry_p0 = diff_ext_p0[WIDTH];
                ovf_p0   = sub_ovf(a_p0, b_p0, res_p0);
            end
            OP_SHL:  carry_p0 = a_p0[WIDTH-1];
            OP_SHR:  carry_p0 = a_p0[0];
            default: carry_p0 = 1'b0;
        endcase
    end

    // Stage p1: flag register, order {z, c, v, n}
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_p1 <= 4'b0000;
        end else if (bus.alu_sel) begin
            flags_p1 <= {(res_p0 == '0), carry_p0, ovf_p0, res_p0[WIDTH-1]};
        end
    end

    assign bus.flag_z = flags_p1[3];
    assign bus.flag_c = flags_p1[2];
    assign bus.flag_v = flags_p1[1];
    assign bus.flag_n = flags_p1[0];

`else

    assign bus.flag_z = 1'b0;
    assign bus.flag_c = 1'b0;
    assign bus.flag_v = 1'b0;
    assign bus.flag_n = 1'b0;

`endif

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu (WIDTH=8); flag expectations follow ALU_FLAGS_EN.
module tb_alu;
    localparam int WIDTH = 8;
`ifdef ALU_FLAGS_EN
    localparam logic [3:0] FMASK = 4'hF;
`else
    localparam logic [3:0] FMASK = 4'h0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_if #(.WIDTH(WIDTH)) bus ();

    alu #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [3:0] flags;
    assign flags = {bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_n};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.alu_sel = 1'b0;
        bus.alu_order = 3'b000;
        bus.reg_1 = 8'h00;
        bus.reg_2 = 8'h00;
        tick();
        rst = 1'b0;
        bus.reg_1 = 8'hF0;
        bus.reg_2 = 8'h0F;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.alu_out !== 8'h00) begin
                errors++;
                $display("FAIL reset_out cyc%0d got=%h exp=00", i, bus.alu_out);
            end
            checks++;
            if (bus.alu_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid cyc%0d got=%b exp=0", i, bus.alu_valid);
            end
            checks++;
            if (flags !== 4'h0) begin
                errors++;
                $display("FAIL reset_flags cyc%0d got=%b exp=0000", i, flags);
            end
        end
    endtask

    task automatic test_all_ops();
        logic [7:0] exp_out [8];
        logic [3:0] exp_fl  [8];
        exp_out = '{8'hFF, 8'hE1, 8'h00, 8'hFF, 8'hFF, 8'h0F, 8'hE0, 8'h78};
        exp_fl  = '{4'b0001, 4'b0001, 4'b1000, 4'b0001,
                    4'b0001, 4'b0000, 4'b0101, 4'b0000};
        bus.reg_1 = 8'hF0;
        bus.reg_2 = 8'h0F;
        bus.alu_sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.alu_order = 3'(i);
            tick();
            checks++;
            if (bus.alu_out !== exp_out[i]) begin
                errors++;
                $display("FAIL ops_out op%0d got=%h exp=%h", i, bus.alu_out, exp_out[i]);
            end
            checks++;
            if (bus.alu_valid !== 1'b1) begin
                errors++;
                $display("FAIL ops_valid op%0d got=%b exp=1", i, bus.alu_valid);
            end
            checks++;
            if (flags !== (exp_fl[i] & FMASK)) begin
                errors++;
                $display("FAIL ops_flags op%0d got=%b exp=%b", i, flags, exp_fl[i] & FMASK);
            end
        end
        bus.alu_sel = 1'b0;
        tick();
        checks++;
        if (bus.alu_valid !== 1'b0) begin
            errors++;
            $display("FAIL ops_idle_valid got=%b exp=0", bus.alu_valid);
        end
    endtask

    task automatic test_add_boundaries();
        logic [7:0] a   [3];
        logic [7:0] b   [3];
        logic [2:0] op  [3];
        logic [7:0] eo  [3];
        logic [3:0] ef  [3];
        a  = '{8'h7F, 8'hFF, 8'h80};
        b  = '{8'h01, 8'h01, 8'h01};
        op = '{3'b000, 3'b000, 3'b001};
        eo = '{8'h80, 8'h00, 8'h7F};
        ef = '{4'b0011, 4'b1100, 4'b0010};
        for (int i = 0; i < 3; i++) begin
            bus.reg_1 = a[i];
            bus.reg_2 = b[i];
            bus.alu_order = op[i];
            bus.alu_sel = 1'b1;
            tick();
            bus.alu_sel = 1'b0;
            checks++;
            if (bus.alu_out !== eo[i]) begin
                errors++;
                $display("FAIL bound_out v%0d got=%h exp=%h", i, bus.alu_out, eo[i]);
            end
            checks++;
            if (flags !== (ef[i] & FMASK)) begin
                errors++;
                $display("FAIL bound_flags v%0d got=%b exp=%b", i, flags, ef[i] & FMASK);
            end
        end
    endtask

    task automatic test_sub_hold();
        bus.reg_1 = 8'h00;
        bus.reg_2 = 8'h01;
        bus.alu_order = 3'b001;
        bus.alu_sel = 1'b1;
        tick();
        bus.alu_sel = 1'b0;
        checks++;
        if (bus.alu_out !== 8'hFF || flags !== (4'b0101 & FMASK)) begin
            errors++;
            $display("FAIL sub_borrow got=%h/%b exp=ff/%b", bus.alu_out, flags, 4'b0101 & FMASK);
        end
        bus.reg_1 = 8'h12;
        bus.reg_2 = 8'h34;
        bus.alu_order = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.alu_out !== 8'hFF || flags !== (4'b0101 & FMASK) || bus.alu_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold cyc%0d got=%h/%b/v%b exp=ff/%b/v0",
                         i, bus.alu_out, flags, bus.alu_valid, 4'b0101 & FMASK);
            end
        end
    endtask

    task automatic test_reset_priority();
        bus.reg_1 = 8'h01;
        bus.reg_2 = 8'h01;
        bus.alu_order = 3'b000;
        bus.alu_sel = 1'b1;
        rst = 1'b1;
        tick();
        checks++;
        if (bus.alu_out !== 8'h00 || bus.alu_valid !== 1'b0 || flags !== 4'h0) begin
            errors++;
            $display("FAIL rst_prio got=%h/v%b/%b exp=00/v0/0000", bus.alu_out, bus.alu_valid, flags);
        end
        rst = 1'b0;
        tick();
        bus.alu_sel = 1'b0;
        checks++;
        if (bus.alu_out !== 8'h02 || bus.alu_valid !== 1'b1 || flags !== 4'h0) begin
            errors++;
            $display("FAIL post_rst_op got=%h/v%b/%b exp=02/v1/0000", bus.alu_out, bus.alu_valid, flags);
        end
    endtask

    initial begin
        test_reset();
        test_all_ops();
        test_add_boundaries();
        test_sub_hold();
        test_reset_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
